// File: rtl/vrc6_mapper_core.sv
`default_nettype none
// ============================================================================
//  Module   : vrc6_mapper_core
//  Purpose  : VRC6-family cartridge mapper core. It holds the PRG/CHR bank
//             registers and the mirroring/WRAM control, and it contains the
//             VRC IRQ counter, which runs in CPU-cycle or scanline-prescaler
//             mode. SWAP_A01 selects the VRC6b board wiring, where CPU A0 and
//             A1 are exchanged.
//  Ports    : clk          M2-rate clock, rising-edge
//             reset_n      synchronous active-low reset
//             cpu_addr     CPU address bus
//             cpu_data_in  CPU write data
//             cpu_rw       1 = read, 0 = write
//             ppu_addr     PPU address bus
//             prg_addr     PRG ROM byte address
//             prg_oe       PRG ROM output enable
//             wram_ce      WRAM chip enable ($6000-$7FFF when enabled)
//             wram_we      WRAM write enable
//             chr_addr     CHR byte address
//             ciram_ce     console nametable RAM enable
//             ciram_a10    nametable select
//             irq          registered IRQ request, active-high
//  Revision : 1.0  initial release
// ============================================================================
module vrc6_mapper_core #(
    parameter int SWAP_A01 = 0,
    parameter int PRG_BITS = 8,
    parameter int CHR_BITS = 8,
    parameter int PRESCALE = 341
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [15:0]           cpu_addr,
    input  logic [7:0]            cpu_data_in,
    input  logic                  cpu_rw,
    input  logic [13:0]           ppu_addr,
    output logic [PRG_BITS+12:0]  prg_addr,
    output logic                  prg_oe,
    output logic                  wram_ce,
    output logic                  wram_we,
    output logic [CHR_BITS+9:0]   chr_addr,
    output logic                  ciram_ce,
    output logic                  ciram_a10,
    output logic                  irq
);

    localparam logic signed [9:0] c_prescale = 10'(PRESCALE);
    localparam logic signed [9:0] c_step     = 10'sd3;

    logic [PRG_BITS-1:0]   r_prg16;
    logic [PRG_BITS-1:0]   r_prg8;
    logic [CHR_BITS-1:0]   r_chr [8];
    logic [1:0]            r_mirr;
    logic                  r_wram_en;
    logic [7:0]            r_latch;
    logic [7:0]            r_counter;
    logic signed [9:0]     r_prescaler;
    logic                  r_ctrl_a;
    logic                  r_ctrl_e;
    logic                  r_ctrl_m;
    logic                  r_irq;

    logic [1:0]            w_a;
    logic [4:0]            w_sel;
    logic                  w_wr;
    logic [PRG_BITS-1:0]   w_prg_data;
    logic [CHR_BITS-1:0]   w_chr_data;
    logic                  w_tick;
    logic                  w_wrap;
    logic signed [9:0]     w_presc_next;

    // Register-select bits; VRC6b boards cross CPU A0/A1 onto the chip.
    assign w_a        = (SWAP_A01 != 0) ? {cpu_addr[0], cpu_addr[1]} : cpu_addr[1:0];
    assign w_sel      = {cpu_addr[14:12], w_a};
    assign w_wr       = cpu_addr[15] & ~cpu_rw;
    assign w_prg_data = PRG_BITS'(cpu_data_in);
    assign w_chr_data = CHR_BITS'(cpu_data_in);

    // Tick source. The prescaler counts PPU dots in steps of 3 per CPU
    // cycle, so the line length averages PRESCALE/3 CPU cycles.
    always_comb begin
        w_tick       = 1'b0;
        w_presc_next = r_prescaler;
        if (r_ctrl_e) begin
            if (r_ctrl_m) begin
                w_tick = 1'b1;
            end else if (r_prescaler <= c_step) begin
                w_tick       = 1'b1;
                w_presc_next = r_prescaler - c_step + c_prescale;
            end else begin
                w_presc_next = r_prescaler - c_step;
            end
        end
    end

    assign w_wrap = w_tick && (r_counter == 8'hFF);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_prg16     <= '0;
            r_prg8      <= '0;
            for (int i = 0; i < 8; i++) begin
                r_chr[i] <= '0;
            end
            r_mirr      <= 2'd0;
            r_wram_en   <= 1'b0;
            r_latch     <= 8'h00;
            r_counter   <= 8'h00;
            r_prescaler <= c_prescale;
            r_ctrl_a    <= 1'b0;
            r_ctrl_e    <= 1'b0;
            r_ctrl_m    <= 1'b0;
            r_irq       <= 1'b0;
        end else begin
            if (w_wr && cpu_addr[14:12] == 3'b000) r_prg16 <= w_prg_data;
            if (w_wr && cpu_addr[14:12] == 3'b100) r_prg8  <= w_prg_data;
            if (w_wr && cpu_addr[14:12] == 3'b101) r_chr[{1'b0, w_a}] <= w_chr_data;
            if (w_wr && cpu_addr[14:12] == 3'b110) r_chr[{1'b1, w_a}] <= w_chr_data;
            if (w_wr && w_sel == 5'b01111) begin
                r_mirr    <= cpu_data_in[3:2];
                r_wram_en <= cpu_data_in[7];
            end
            if (w_wr && w_sel == 5'b11100) r_latch <= cpu_data_in;

            if (w_wr && w_sel == 5'b11101) begin
                // Control write takes precedence over any tick this cycle.
                r_ctrl_a <= cpu_data_in[0];
                r_ctrl_e <= cpu_data_in[1];
                r_ctrl_m <= cpu_data_in[2];
                r_irq    <= 1'b0;
                if (cpu_data_in[1]) begin
                    r_counter   <= r_latch;
                    r_prescaler <= c_prescale;
                end
            end else begin
                if (w_wr && w_sel == 5'b11110) begin
                    r_ctrl_e <= r_ctrl_a;
                    r_irq    <= 1'b0;
                end
                r_prescaler <= w_presc_next;
                if (w_tick) begin
                    r_counter <= w_wrap ? r_latch : r_counter + 8'd1;
                end
                // Placed after the acknowledge so a coincident wrap wins.
                if (w_wrap) r_irq <= 1'b1;
            end
        end
    end

    always_comb begin
        case (cpu_addr[15:13])
            3'b100, 3'b101: prg_addr = {r_prg16[PRG_BITS-2:0], cpu_addr[13:0]};
            3'b110:         prg_addr = {r_prg8, cpu_addr[12:0]};
            default:        prg_addr = {{PRG_BITS{1'b1}}, cpu_addr[12:0]};
        endcase
        case (r_mirr)
            2'd0:    ciram_a10 = ppu_addr[10];
            2'd1:    ciram_a10 = ppu_addr[11];
            2'd2:    ciram_a10 = 1'b0;
            default: ciram_a10 = 1'b1;
        endcase
    end

    assign chr_addr = {r_chr[ppu_addr[12:10]], ppu_addr[9:0]};
    assign prg_oe   = cpu_rw & cpu_addr[15];
    assign wram_ce  = r_wram_en && (cpu_addr[15:13] == 3'b011);
    assign wram_we  = wram_ce & ~cpu_rw;
    assign ciram_ce = ~ppu_addr[13];
    assign irq      = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_vrc6_mapper_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vrc6_mapper_core
//  Purpose  : Scoreboard bench for vrc6_mapper_core. Two instances (VRC6a and
//             VRC6b decode) share one CPU/PPU stimulus; expected outputs are
//             queued by the stimulus and checked by a monitor on the falling
//             clock edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vrc6_mapper_core;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data_in;
    logic        cpu_rw;
    logic [13:0] ppu_addr;

    logic [20:0] prg_addr_a, prg_addr_b;
    logic [17:0] chr_addr_a, chr_addr_b;
    logic prg_oe_a, wram_ce_a, wram_we_a, ciram_ce_a, ciram_a10_a, irq_a;
    logic prg_oe_b, wram_ce_b, wram_we_b, ciram_ce_b, ciram_a10_b, irq_b;

    always #5 clk = ~clk;

    vrc6_mapper_core #(.SWAP_A01(0), .PRG_BITS(8), .CHR_BITS(8), .PRESCALE(341)) dut_a (
        .clk(clk), .reset_n(reset_n), .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in),
        .cpu_rw(cpu_rw), .ppu_addr(ppu_addr), .prg_addr(prg_addr_a), .prg_oe(prg_oe_a),
        .wram_ce(wram_ce_a), .wram_we(wram_we_a), .chr_addr(chr_addr_a),
        .ciram_ce(ciram_ce_a), .ciram_a10(ciram_a10_a), .irq(irq_a));

    vrc6_mapper_core #(.SWAP_A01(1), .PRG_BITS(8), .CHR_BITS(8), .PRESCALE(341)) dut_b (
        .clk(clk), .reset_n(reset_n), .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in),
        .cpu_rw(cpu_rw), .ppu_addr(ppu_addr), .prg_addr(prg_addr_b), .prg_oe(prg_oe_b),
        .wram_ce(wram_ce_b), .wram_we(wram_we_b), .chr_addr(chr_addr_b),
        .ciram_ce(ciram_ce_b), .ciram_a10(ciram_a10_b), .irq(irq_b));

    localparam int S_PRG = 0, S_CHR = 1, S_CHR_B = 2, S_A10 = 3, S_WCE = 4,
                   S_WWE = 5, S_IRQ = 6, S_OE = 7, S_CE = 8;

    typedef struct {
        int          sel;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            S_PRG:   return 32'(prg_addr_a);
            S_CHR:   return 32'(chr_addr_a);
            S_CHR_B: return 32'(chr_addr_b);
            S_A10:   return 32'(ciram_a10_a);
            S_WCE:   return 32'(wram_ce_a);
            S_WWE:   return 32'(wram_we_a);
            S_IRQ:   return 32'(irq_a);
            S_OE:    return 32'(prg_oe_a);
            default: return 32'(ciram_ce_a);
        endcase
    endfunction

    // Monitor: every entry queued during a cycle is compared at its falling edge.
    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [31:0] act;
        while (sb.size() != 0) begin
            e   = sb.pop_front();
            act = observe(e.sel);
            n_checks++;
            if (act !== e.exp) begin
                n_fail++;
                $display("FAIL %s: actual %0h required %0h", e.name, act, e.exp);
            end
        end
    end

    task automatic push_exp(input int sel, input logic [31:0] v, input string nm);
        exp_t e;
        e.sel  = sel;
        e.exp  = v;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic idle();
        cpu_addr    = 16'h0000;
        cpu_rw      = 1'b1;
        cpu_data_in = 8'h00;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
        cpu_addr    = a;
        cpu_data_in = d;
        cpu_rw      = 1'b0;
        step();
        idle();
    endtask

    task automatic rd(input logic [15:0] a);
        cpu_addr = a;
        cpu_rw   = 1'b1;
    endtask

    initial begin
        #1000000;
        n_fail++;
        $display("FAIL watchdog: actual timeout required finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        reset_n  = 1'b0;
        ppu_addr = 14'h0000;
        idle();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Reset state
        rd(16'h8123); ppu_addr = 14'h0ABC;
        push_exp(S_PRG, 32'h00123, "rst_prg_8123");
        push_exp(S_CHR, 32'h002BC, "rst_chr_0abc");
        push_exp(S_A10, 32'd0, "rst_a10_0abc");
        push_exp(S_IRQ, 32'd0, "rst_irq");
        push_exp(S_OE, 32'd1, "prg_oe_read");
        push_exp(S_CE, 32'd1, "ciram_ce_0abc");
        step();
        rd(16'hC123); ppu_addr = 14'h0400;
        push_exp(S_PRG, 32'h00123, "rst_prg_c123");
        push_exp(S_A10, 32'd1, "rst_a10_0400");
        step();
        rd(16'h6000);
        push_exp(S_WCE, 32'd0, "rst_wram_ce");
        step();

        // CHR banking, VRC6a vs VRC6b register decode
        cpu_wr(16'hD002, 8'h15);
        ppu_addr = 14'h0ABC;
        push_exp(S_CHR, 32'h056BC, "chr_a_slot2");
        push_exp(S_CHR_B, 32'h002BC, "chr_b_slot2");
        step();
        ppu_addr = 14'h0400;
        push_exp(S_CHR, 32'h00000, "chr_a_slot1");
        push_exp(S_CHR_B, 32'h05400, "chr_b_slot1");
        step();
        cpu_wr(16'hE003, 8'h2A);
        ppu_addr = 14'h1C05;
        push_exp(S_CHR, 32'h0A805, "chr_a_slot7");
        push_exp(S_CHR_B, 32'h0A805, "chr_b_slot7");
        step();

        // PRG banking
        cpu_wr(16'h8000, 8'h03);
        cpu_wr(16'hC000, 8'h09);
        rd(16'h8123); push_exp(S_PRG, 32'h0C123, "prg_8123"); step();
        rd(16'hA000); push_exp(S_PRG, 32'h0E000, "prg_a000"); step();
        rd(16'hC123); push_exp(S_PRG, 32'h12123, "prg_c123"); step();
        rd(16'hE123); push_exp(S_PRG, 32'h1FE123, "prg_e123"); step();

        // Mirroring and WRAM
        cpu_wr(16'hB003, 8'h84);
        rd(16'h6000); ppu_addr = 14'h0800;
        push_exp(S_WCE, 32'd1, "wram_ce_en");
        push_exp(S_A10, 32'd1, "a10_m1_0800");
        step();
        cpu_addr = 16'h6000; cpu_rw = 1'b0; ppu_addr = 14'h0400;
        push_exp(S_WWE, 32'd1, "wram_we_en");
        push_exp(S_A10, 32'd0, "a10_m1_0400");
        push_exp(S_OE, 32'd0, "prg_oe_wram");
        step();
        idle();
        cpu_wr(16'hB003, 8'h8C);
        ppu_addr = 14'h0000; push_exp(S_A10, 32'd1, "a10_m3"); step();
        cpu_wr(16'hB003, 8'h88);
        ppu_addr = 14'h0C00; push_exp(S_A10, 32'd0, "a10_m2"); step();
        cpu_wr(16'hB003, 8'h00);
        rd(16'h6000); ppu_addr = 14'h0400;
        push_exp(S_WCE, 32'd0, "wram_ce_dis");
        push_exp(S_A10, 32'd1, "a10_m0_0400");
        step();
        cpu_wr(16'hB002, 8'h8C);
        ppu_addr = 14'h2000;
        push_exp(S_A10, 32'd0, "b002_ignored");
        push_exp(S_CE, 32'd0, "ciram_ce_2000");
        step();

        // CPU-cycle IRQ: latch $FC, ctrl A=1 E=1 M=1
        cpu_wr(16'hF000, 8'hFC);
        cpu_wr(16'hF001, 8'h07);
        push_exp(S_IRQ, 32'd0, "cyc_irq_e0");
        for (int n = 1; n <= 4; n++) begin
            step();
            push_exp(S_IRQ, (n == 4) ? 32'd1 : 32'd0, "cyc_irq_first");
        end
        cpu_wr(16'hF002, 8'h00);
        push_exp(S_IRQ, 32'd0, "cyc_ack_clear");
        step(); push_exp(S_IRQ, 32'd0, "cyc_irq_e6");
        step(); push_exp(S_IRQ, 32'd0, "cyc_irq_e7");
        cpu_wr(16'hF002, 8'h00);
        push_exp(S_IRQ, 32'd1, "cyc_ack_vs_wrap");
        step(); push_exp(S_IRQ, 32'd1, "cyc_irq_hold");
        cpu_wr(16'hF001, 8'h00);
        push_exp(S_IRQ, 32'd0, "cyc_ctrl_clear");
        for (int n = 0; n < 8; n++) begin
            step(); push_exp(S_IRQ, 32'd0, "cyc_stopped");
        end

        // Scanline mode: latch $FE, ctrl E=1 M=0; ticks at edges 114 and 228
        cpu_wr(16'hF000, 8'hFE);
        cpu_wr(16'hF001, 8'h02);
        push_exp(S_IRQ, 32'd0, "scan_irq_e0");
        for (int n = 1; n <= 228; n++) begin
            step();
            push_exp(S_IRQ, (n == 228) ? 32'd1 : 32'd0, "scan_irq_edge");
        end
        cpu_wr(16'hF001, 8'h00);
        push_exp(S_IRQ, 32'd0, "scan_ctrl_clear");
        for (int n = 0; n < 300; n++) begin
            step(); push_exp(S_IRQ, 32'd0, "scan_stopped");
        end

        // Reset mid-count with a simultaneous PRG write
        cpu_wr(16'hB003, 8'h84);
        cpu_wr(16'hF000, 8'hFC);
        cpu_wr(16'hF001, 8'h07);
        step();
        step();
        reset_n = 1'b0; cpu_addr = 16'h8000; cpu_data_in = 8'h05; cpu_rw = 1'b0;
        step();
        reset_n = 1'b1;
        idle();
        push_exp(S_IRQ, 32'd0, "rst2_irq");
        for (int n = 0; n < 8; n++) begin
            step(); push_exp(S_IRQ, 32'd0, "rst2_irq_aborted");
        end
        rd(16'h8123); ppu_addr = 14'h0ABC;
        push_exp(S_PRG, 32'h00123, "rst2_prg16");
        push_exp(S_CHR, 32'h002BC, "rst2_chr2");
        step();
        rd(16'hC123); ppu_addr = 14'h1C05;
        push_exp(S_PRG, 32'h00123, "rst2_prg8");
        push_exp(S_CHR, 32'h00005, "rst2_chr7");
        step();
        rd(16'h6000); ppu_addr = 14'h0800;
        push_exp(S_WCE, 32'd0, "rst2_wram_en");
        push_exp(S_A10, 32'd0, "rst2_mirr");
        step();
        idle();
        // Latch was cleared: first IRQ comes 256 cycles after ctrl.
        cpu_wr(16'hF001, 8'h07);
        push_exp(S_IRQ, 32'd0, "rst2_latch0_e0");
        for (int n = 1; n <= 256; n++) begin
            step();
            push_exp(S_IRQ, (n == 256) ? 32'd1 : 32'd0, "rst2_latch0_irq");
        end

        @(negedge clk);
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: actual %0d pending required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
